reg_file_sb: RTL and testbench

- Parametrised successor to the 3-port MIPS-style register file: two combinational read ports and one clocked write port.
- Adds a per-register busy scoreboard for the issue stage, a hardware clear sweep after reset, and optional write-to-read bypass.
- Sits between decode/issue (read and scoreboard check) and writeback (write port).

---
 rtl/reg_file_sb.sv | 147 ++++++++++++++
 tb/tb_reg_file_sb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 2-read / 1-write register file with a per-register
// busy scoreboard and a hardware clear sweep that runs after every reset.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   ready               high once the clear sweep has finished (RUN)
//   we3, wa3, wd3       write port (writeback), clears busy of the target
//   ra1/rd1, ra2/rd2    combinational read ports
//   iss_en, iss_ra      issue port: marks the destination register busy
//   busy1, busy2        scoreboard bits for ra1 / ra2, combinational
//
// Optional feature: define REG_FILE_SB_BYPASS_EN to forward a same-cycle
// write to the read ports (data forwarded, busy forced low).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_CLEAR| sweeping zeros into reg[ptr]; reads and busy forced to 0,
//         | write and issue ports ignored
// ST_RUN  | normal operation

module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_ra,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [WIDTH-1:0]  wr_data_d;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Register contents are deliberately not reset; the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wa3;
        wr_data_d = wd3;
        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (we3 && !is_zero(wa3)) begin
                    wr_en_d     = 1'b1;
                    busy_d[wa3] = 1'b0;
                end
                // Issue is applied after the write so a new producer wins.
                if (iss_en && !is_zero(iss_ra)) begin
                    busy_d[iss_ra] = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign ready = (state_q == ST_RUN);

    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (ready && !is_zero(ra1)) begin
            rd1   = regs_q[ra1];
            busy1 = busy_q[ra1];
`ifdef REG_FILE_SB_BYPASS_EN
            if (we3 && (wa3 == ra1)) begin
                rd1   = wd3;
                busy1 = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (ready && !is_zero(ra2)) begin
            rd2   = regs_q[ra2];
            busy2 = busy_q[ra2];
`ifdef REG_FILE_SB_BYPASS_EN
            if (we3 && (wa3 == ra2)) begin
                rd2   = wd3;
                busy2 = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb (default parameters). Expectations are queued by
// the stimulus process and checked by an independent negedge monitor.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        iss_en;
    logic [4:0]  iss_ra;
    logic        busy1, busy2;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // mask bits: [0] ready [1] rd1 [2] rd2 [3] busy1 [4] busy2
    typedef struct {
        string       name;
        logic [4:0]  mask;
        logic        rdy;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t sb_q[$];

    reg_file_sb dut (
        .clk    (clk),
        .reset  (reset),
        .ready  (ready),
        .we3    (we3),
        .wa3    (wa3),
        .wd3    (wd3),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .iss_en (iss_en),
        .iss_ra (iss_ra),
        .busy1  (busy1),
        .busy2  (busy2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [4:0] mask,
                              input logic rdy, input logic [31:0] d1,
                              input logic [31:0] d2, input logic b1,
                              input logic b2);
        exp_t e;
        e.name = name; e.mask = mask; e.rdy = rdy;
        e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        we3 = 1'b0; wa3 = '0; wd3 = '0;
        iss_en = 1'b0; iss_ra = '0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.mask[0]) begin
                n_tests++;
                if (ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL %s ready: got %b want %b", e.name, ready, e.rdy);
                end
            end
            if (e.mask[1]) begin
                n_tests++;
                if (rd1 !== e.d1) begin
                    n_fail++;
                    $display("FAIL %s rd1: got %h want %h", e.name, rd1, e.d1);
                end
            end
            if (e.mask[2]) begin
                n_tests++;
                if (rd2 !== e.d2) begin
                    n_fail++;
                    $display("FAIL %s rd2: got %h want %h", e.name, rd2, e.d2);
                end
            end
            if (e.mask[3]) begin
                n_tests++;
                if (busy1 !== e.b1) begin
                    n_fail++;
                    $display("FAIL %s busy1: got %b want %b", e.name, busy1, e.b1);
                end
            end
            if (e.mask[4]) begin
                n_tests++;
                if (busy2 !== e.b2) begin
                    n_fail++;
                    $display("FAIL %s busy2: got %b want %b", e.name, busy2, e.b2);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        ra1 = 5'd31; ra2 = 5'd0;

        // Reset for one edge, then release and count the sweep.
        step();
        reset = 1'b0;
        expect_out("after_reset", 5'b11111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            step();
            ra2 = 5'(i);
            // Write and issue during the sweep must be ignored.
            if (i == 5) begin
                we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h1111_1111;
                iss_en = 1'b1; iss_ra = 5'd4;
            end else begin
                idle_inputs();
            end
            if (i < 32)
                expect_out("sweep", 5'b11111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            else
                expect_out("sweep_done", 5'b00001, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 32; i++) begin
            step();
            ra1 = 5'(i); ra2 = 5'(31 - i);
            expect_out("cleared", 5'b11111, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        // Writes and dual reads.
        step();
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd5;
        expect_out("wr5_same", 5'b00110, 1'b1, BYP ? 32'hDEAD_BEEF : 32'h0,
                   BYP ? 32'hDEAD_BEEF : 32'h0, 1'b0, 1'b0);
        step();
        idle_inputs();
        expect_out("rd5_both", 5'b11111, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h1234_5678; ra1 = 5'd5; ra2 = 5'd10;
        expect_out("wr10_same", 5'b00110, 1'b1, 32'hDEAD_BEEF,
                   BYP ? 32'h1234_5678 : 32'h0, 1'b0, 1'b0);
        step();
        idle_inputs();
        expect_out("rd5_rd10", 5'b00110, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);

        // Scoreboard on reg7.
        step();
        iss_en = 1'b1; iss_ra = 5'd7; ra1 = 5'd7; ra2 = 5'd5;
        expect_out("iss7_same", 5'b11000, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        iss_en = 1'b1; iss_ra = 5'd7; we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hCAFE_BABE;
        expect_out("iss7_busy", 5'b01010, 1'b1, BYP ? 32'hCAFE_BABE : 32'h0, 32'h0,
                   BYP ? 1'b0 : 1'b1, 1'b0);
        step();
        idle_inputs();
        expect_out("iss_wr7_busy", 5'b01010, 1'b1, 32'hCAFE_BABE, 32'h0, 1'b1, 1'b0);
        step();
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hCAFE_BABE;
        expect_out("wr7_same", 5'b01010, 1'b1, 32'hCAFE_BABE, 32'h0,
                   BYP ? 1'b0 : 1'b1, 1'b0);
        step();
        idle_inputs();
        expect_out("wr7_free", 5'b11010, 1'b1, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b0);

        // Zero register.
        step();
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_ra = 5'd0; ra1 = 5'd0;
        expect_out("zero_same", 5'b01010, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle_inputs();
        expect_out("zero_after", 5'b01010, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // Bypass behaviour on reg3 (prior value 0).
        step();
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hA5A5_A5A5; ra1 = 5'd3;
        expect_out("byp3_same", 5'b00010, 1'b1, BYP ? 32'hA5A5_A5A5 : 32'h0,
                   32'h0, 1'b0, 1'b0);
        step();
        idle_inputs();
        expect_out("byp3_after", 5'b00010, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);

        // Reset mid-sweep with a busy bit set beforehand.
        step();
        iss_en = 1'b1; iss_ra = 5'd9; ra1 = 5'd9; ra2 = 5'd5;
        step();
        idle_inputs();
        expect_out("iss9_busy", 5'b01001, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_out("rst2", 5'b11111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step();
            expect_out("sweep2", 5'b00001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i < 32)
                expect_out("sweep3", 5'b11111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            else
                expect_out("sweep3_done", 5'b11111, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        // Let the monitor drain, then confirm nothing was left unchecked.
        step();
        @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
